osc_freq_monitor: RTL

Measures the on-chip oscillator clock frequency against an external reference square wave, such as a 1 kHz crystal-derived tick. It counts oscillator cycles across a programmable number of reference periods and reports the count with a valid strobe, plus timeout, overflow and optional range-error status. The block sits downstream of the oscillator wrapper and runs directly on its output (105 MHz on GW1N-4 at FREQ_DIV=2). It is used for board bring-up and for run-time oscillator drift supervision.

---
 rtl/osc_freq_mon_pkg.sv | 19 +
 rtl/ref_edge_sync.sv | 31 +++
 rtl/osc_freq_monitor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/osc_freq_mon_pkg.sv
// Shared state encoding and default constants for the oscillator frequency monitor.
// Defaults assume a 105 MHz oscillator measured against a 1 kHz reference tick.
package osc_freq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CNT_W          = 24;
    localparam int DEF_REF_PERIODS    = 1;
    localparam int DEF_TIMEOUT_CYCLES = 1 << 20;
    localparam int NOM_EXP_COUNT      = 105000;
    localparam int DEF_EXP_MIN        = 99750;
    localparam int DEF_EXP_MAX        = 110250;

endpackage

// File: rtl/ref_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for the reference input.
// Latency: ref_in edge to ref_rise is 3 clk cycles; no backpressure.
module ref_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_in,
    output logic ref_rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= ref_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign ref_rise = rise_q;

endmodule

// File: rtl/osc_freq_monitor.sv
// Counts clk cycles over REF_PERIODS reference periods; result strobes 1 cycle after the terminal edge.
// No backpressure; range_err is live only when OSC_FREQ_MON_RANGE_CHECK_EN is defined.
module osc_freq_monitor
    import osc_freq_mon_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int REF_PERIODS    = DEF_REF_PERIODS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int EXP_MIN        = DEF_EXP_MIN,
    parameter int EXP_MAX        = DEF_EXP_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_timeout,
    output logic             meas_ovf,
    output logic             range_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PER_W = $clog2(REF_PERIODS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(REF_PERIODS - 1);

    logic ref_rise;

    ref_edge_sync u_ref_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ref_in   (ref_in),
        .ref_rise (ref_rise)
    );

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [PER_W-1:0]   per_q,     per_d;
    logic [TMO_W-1:0]   tmo_q,     tmo_d;
    logic               ovf_q,     ovf_d;
    logic               busy_q,    busy_d;
    logic               valid_q,   valid_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               timeout_q, timeout_d;
    logic               movf_q,    movf_d;

    logic               cnt_at_max;
    logic [CNT_W-1:0]   cnt_inc;
    logic               tmo_hit;

    assign cnt_at_max = &cnt_q;
    assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + CNT_W'(1);
    assign tmo_hit    = (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        tmo_d     = tmo_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        count_d   = count_q;
        timeout_d = timeout_q;
        movf_d    = movf_q;

        case (state_q)
            IDLE: begin
                tmo_d  = '0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                end
            end
            ARM: begin
                if (ref_rise) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                    per_d   = '0;
                    ovf_d   = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d   = DONE;
                    valid_d   = 1'b1;
                    count_d   = '0;
                    timeout_d = 1'b1;
                    movf_d    = 1'b0;
                    busy_d    = continuous;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            COUNT: begin
                cnt_d = cnt_inc;
                if (cnt_at_max) begin
                    ovf_d = 1'b1;
                end
                // A reference edge on the timeout terminal cycle still counts as a live edge.
                if (ref_rise) begin
                    tmo_d = '0;
                    per_d = per_q + PER_W'(1);
                    if (per_q == PER_LAST) begin
                        state_d   = DONE;
                        valid_d   = 1'b1;
                        count_d   = cnt_inc;
                        timeout_d = 1'b0;
                        movf_d    = ovf_q | cnt_at_max;
                        busy_d    = continuous;
                    end
                end else if (tmo_hit) begin
                    state_d   = DONE;
                    valid_d   = 1'b1;
                    count_d   = '0;
                    timeout_d = 1'b1;
                    movf_d    = ovf_q;
                    busy_d    = continuous;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                tmo_d = '0;
                if (continuous) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            tmo_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            movf_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            movf_q    <= movf_d;
        end
    end

`ifdef OSC_FREQ_MON_RANGE_CHECK_EN
    localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);

    logic range_q, range_d;

    always_comb begin
        range_d = range_q;
        if (valid_d) begin
            range_d = (count_d < EXP_MIN_C) | (count_d > EXP_MAX_C) | timeout_d | movf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_q <= 1'b0;
        end else begin
            range_q <= range_d;
        end
    end

    assign range_err = range_q;
`else
    assign range_err = 1'b0;
`endif

    assign busy         = busy_q;
    assign meas_valid   = valid_q;
    assign meas_count   = count_q;
    assign meas_timeout = timeout_q;
    assign meas_ovf     = movf_q;

endmodule
